// File: rtl/tx_sched_pkg.sv
// ---------------------------------------------------------------------------
// tx_sched_pkg: shared state encoding, ms divider and BCD decode.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tx_sched_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;
  localparam int unsigned MS_DIV           = CLK_FREQ_DEFAULT / 1000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    WAIT_TX  = 3'd3,
    GAP      = 3'd4,
    FINISH   = 3'd5
  } state_t;

  // Divider for an arbitrary clock; never below 1 so a tick always exists.
  function automatic int unsigned ms_div(input int unsigned clk_freq);
    return (clk_freq >= 1000) ? clk_freq / 1000 : 1;
  endfunction

  // Two BCD digits to binary; out-of-range nibbles clamp to 9.
  function automatic logic [6:0] bcd_to_bin(input logic [7:0] bcd);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = (bcd[7:4] > 4'd9) ? 4'd9 : bcd[7:4];
    ones = (bcd[3:0] > 4'd9) ? 4'd9 : bcd[3:0];
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen: one-cycle tick every CLK_FREQ/1000 cycles, restartable.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ms_tick_gen
  import tx_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DIV   = ms_div(CLK_FREQ);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // A clear lands the count at zero so the first tick is exactly DIV cycles later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/tx_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tx_burst_scheduler: sends a burst of identical bytes to the UART with a
// programmable millisecond gap between bytes.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_burst_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_byte,
  input  logic [7:0] tx_count,
  input  logic [7:0] gap_bcd,
  input  logic       uart_busy,
  output logic       uart_start,
  output logic [7:0] uart_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] bytes_sent
);

  state_t     state;
  state_t     state_nx;
  logic [7:0] remaining;
  logic [6:0] gap_ms;
  logic [6:0] gap_cnt;
  logic       tick;
  logic       tick_clear;
  logic       accept;
  logic       byte_done;

  assign accept    = (state == IDLE) && start;
  // Abort beats a simultaneous busy fall, so that byte is never counted.
  assign byte_done = (state == WAIT_TX) && !uart_busy && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    tick_clear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (tx_count == 8'd0) ? FINISH : SEND;
        end
      end
      SEND: begin
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (uart_busy) begin
          state_nx = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (!uart_busy) begin
          if (remaining == 8'd1) begin
            state_nx = FINISH;
          end else if (gap_ms == 7'd0) begin
            state_nx = SEND;
          end else begin
            state_nx = GAP;
          end
        end
      end
      GAP: begin
        if (tick && (gap_cnt + 7'd1 == gap_ms)) begin
          state_nx = SEND;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (abort && (state == SEND || state == WAIT_ACK ||
                  state == WAIT_TX || state == GAP)) begin
      state_nx = FINISH;
    end

    if (state_nx == GAP && state != GAP) begin
      tick_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_data  <= 8'h00;
      remaining  <= 8'h00;
      gap_ms     <= 7'd0;
      bytes_sent <= 8'h00;
    end else if (accept) begin
      uart_data  <= tx_byte;
      remaining  <= tx_count;
      gap_ms     <= bcd_to_bin(gap_bcd);
      bytes_sent <= 8'h00;
    end else if (byte_done) begin
      remaining  <= remaining - 8'd1;
      bytes_sent <= bytes_sent + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= 7'd0;
    end else if (tick_clear) begin
      gap_cnt <= 7'd0;
    end else if (state == GAP && tick) begin
      gap_cnt <= gap_cnt + 7'd1;
    end
  end

  ms_tick_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_ms_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  assign uart_start = (state == SEND);
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

endmodule

`default_nettype wire

// File: tb/tb_tx_burst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tx_burst_scheduler: directed bench with a UART model and byte scoreboard.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tx_burst_scheduler;

  localparam int unsigned CLK_FREQ = 10_000;
  localparam int          MS_DIV   = 10;
  localparam int          BUSY_LEN = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] tx_byte;
  logic [7:0] tx_count;
  logic [7:0] gap_bcd;
  logic       uart_busy;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       busy;
  logic       done;
  logic [7:0] bytes_sent;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int fall_cyc = 0;
  int n_falls = 0;
  int n_starts = 0;
  int n_done = 0;
  int gap_ms_exp = 0;
  bit first_pending = 1'b0;
  int busy_left = 0;
  bit pend = 1'b0;
  logic [7:0] sb[$];

  tx_burst_scheduler #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .tx_byte   (tx_byte),
    .tx_count  (tx_count),
    .gap_bcd   (gap_bcd),
    .uart_busy (uart_busy),
    .uart_start(uart_start),
    .uart_data (uart_data),
    .busy      (busy),
    .done      (done),
    .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model: busy rises the cycle after a start request, lasts BUSY_LEN cycles.
  always @(negedge clk) begin
    if (reset) begin
      uart_busy = 1'b0;
      pend      = 1'b0;
      busy_left = 0;
    end else begin
      if (pend) begin
        uart_busy = 1'b1;
        busy_left = BUSY_LEN;
        pend      = 1'b0;
      end else if (uart_busy) begin
        busy_left--;
        if (busy_left == 0) begin
          uart_busy = 1'b0;
          fall_cyc  = cyc;
          n_falls++;
        end
      end
      if (uart_start) pend = 1'b1;
    end
  end

  // Scoreboard: every uart_start consumes one expected byte and is timed.
  always @(negedge clk) begin
    if (uart_start) begin
      n_starts++;
      if (sb.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        check("uart_data", uart_data, sb.pop_front());
      end
      if (first_pending) begin
        check("first_start_latency", cyc - start_cyc, 1);
        first_pending = 1'b0;
      end else begin
        check("start_spacing", cyc - fall_cyc, 1 + gap_ms_exp * MS_DIV);
      end
    end
    if (done) n_done++;
  end

  task automatic pulse_start(input logic [7:0] b, input logic [7:0] c, input logic [7:0] g);
    @(negedge clk);
    tx_byte   = b;
    tx_count  = c;
    gap_bcd   = g;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic launch(input logic [7:0] b, input logic [7:0] c, input logic [7:0] g,
                        input int ms, input int n_exp);
    for (int i = 0; i < n_exp; i++) sb.push_back(b);
    gap_ms_exp    = ms;
    first_pending = (n_exp > 0);
    pulse_start(b, c, g);
  endtask

  task automatic wait_done(input int bound);
    int i;
    i = 0;
    while (!done && i < bound) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic finish_checks(input string tag, input logic [7:0] exp_sent);
    check({tag, "_bytes_sent"}, bytes_sent, exp_sent);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int base;
    int i;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    tx_byte  = 8'h00;
    tx_count = 8'h00;
    gap_bcd  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_uart_start", uart_start, 1'b0);
    check("rst_uart_data", uart_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bytes_sent", bytes_sent, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, no gap.
    launch(8'hA5, 8'd1, 8'h00, 0, 1);
    wait_done(200);
    check("t1_done_after_fall", cyc - fall_cyc, 1);
    finish_checks("t1", 8'd1);

    // 32 bytes back to back, with an ignored start in the middle.
    launch(8'h3C, 8'h20, 8'h00, 0, 32);
    base = n_starts;
    i = 0;
    while (n_starts < base + 5 && i < 500) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    tx_byte  = 8'h77;
    tx_count = 8'h02;
    gap_bcd  = 8'h20;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t2_data_held", uart_data, 8'h3C);
    wait_done(2000);
    check("t2_done_after_fall", cyc - fall_cyc, 1);
    finish_checks("t2", 8'h20);

    // 5 ms gap: 51 cycles from busy fall to the next start.
    launch(8'h5A, 8'd3, 8'h05, 5, 3);
    wait_done(1000);
    check("t3_done_after_fall", cyc - fall_cyc, 1);
    finish_checks("t3", 8'd3);

    // Abort during the gap after the 4th byte.
    launch(8'hC3, 8'hFF, 8'h05, 5, 4);
    base = n_falls;
    i = 0;
    while (n_falls < base + 4 && i < 1000) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    abort = 1'b1;
    wait_done(20);
    abort = 1'b0;
    base = n_starts;
    finish_checks("t4", 8'd4);
    repeat (80) @(negedge clk);
    check("t4_no_more_starts", n_starts, base);

    // Zero-length burst: done one cycle after start, no UART request.
    base = n_starts;
    launch(8'h11, 8'd0, 8'h00, 0, 0);
    check("t5_done", done, 1'b1);
    check("t5_busy", busy, 1'b1);
    check("t5_no_uart_start", uart_start, 1'b0);
    finish_checks("t5", 8'd0);
    check("t5_start_count", n_starts, base);

    // 0xFF gap decodes to 99 ms: 991 cycles between bytes.
    launch(8'h99, 8'd2, 8'hFF, 99, 2);
    wait_done(3000);
    finish_checks("t6", 8'd2);

    // Reset in the middle of a gap.
    launch(8'h42, 8'd3, 8'h10, 10, 1);
    base = n_falls;
    i = 0;
    while (n_falls < base + 1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    repeat (5) @(negedge clk);
    check("t7_pre_bytes_sent", bytes_sent, 8'd1);
    base = n_done;
    #2 reset = 1'b1;
    #1;
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_uart_data", uart_data, 8'h00);
    check("t7_rst_bytes_sent", bytes_sent, 8'h00);
    check("t7_rst_done", done, 1'b0);
    check("t7_rst_uart_start", uart_start, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    check("t7_no_done", n_done, base);
    check("t7_idle", busy, 1'b0);
    check("t7_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tx_burst_scheduler.md
# tx_burst_scheduler

Sequences the UART transmitter for one burst of identical bytes. On a single-cycle start pulse from the system controller, it captures the data byte, the byte count and the BCD inter-byte gap. It then issues one UART start per byte, waits for each transmission to finish, and inserts the programmed millisecond gap between bytes. It sits between the system controller's latched outputs and the UART transmitter and reports progress to the 7-segment display path.

## Interface
- CLK_FREQ, 100_000_000, clock frequency in Hz; the 1 ms tick period is CLK_FREQ/1000 cycles.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a burst.
- abort  in  1  level; ends the burst early.
- tx_byte  in  8  byte to transmit; sampled on the accepted start.
- tx_count  in  8  number of bytes to send, 0–255; sampled on the accepted start.
- gap_bcd  in  8  inter-byte gap in ms as two BCD digits (0x00, 0x05, 0x10, 0x20 in normal use); sampled on the accepted start.
- uart_busy  in  1  high while the transmitter is shifting a byte.
- uart_start  out  1  one-cycle request to the transmitter.
- uart_data  out  8  byte presented to the transmitter.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at the end of a burst.
- bytes_sent  out  8  number of bytes completed in the current or last burst.

## Operation
- States:
  - IDLE, SEND, WAIT_ACK, WAIT_TX, GAP, FINISH.
  - All outputs are registered or decoded from the state register (Moore).
- Reset: state=IDLE, uart_start=0, uart_data=0x00, busy=0, done=0, bytes_sent=0x00, internal counters=0.
- IDLE:
  - On start=1: capture tx_byte into uart_data, tx_count into remaining, and the binary value of gap_bcd into gap_ms.
  - Clear bytes_sent.
  - If tx_count=0, go to FINISH; otherwise go to SEND.
  - abort is ignored in IDLE.
- SEND: uart_start=1 for exactly this cycle, then go to WAIT_ACK.
- WAIT_ACK: wait for uart_busy=1, then go to WAIT_TX.
- WAIT_TX:
  - On uart_busy=0: bytes_sent+1 and remaining-1.
  - If the new remaining is 0, go to FINISH.
  - Else if gap_ms=0, go to SEND.
  - Else go to GAP.
- GAP:
  - The ms tick counter restarts on entry.
  - Count gap_ms ticks, then go to SEND.
  - No gap is inserted after the final byte.
- FINISH: done=1 for this cycle, then go to IDLE.
- BCD decode: gap_ms = tens*10 + ones. A nibble greater than 9 is clamped to 9, so 0xFF decodes to 99 ms.
- start while busy=1: ignored. Captured operands are held for the whole burst, so changes on the inputs have no effect until the next accepted start.
- abort=1 in any state other than IDLE:
  - Next state is FINISH, and done still pulses.
  - A byte already handed to the UART is not counted if abort precedes its busy fall.
  - abort and start in the same cycle while in IDLE: start wins.
- Reset mid-burst returns immediately to the reset values. No done pulse is produced.

## Timing
- start sampled at edge N → uart_start high during cycle N+1.
- tx_count=0: done high during cycle N+1, busy low again from N+2.
- Byte k completes (uart_busy seen low at edge M):
  - With gap_ms=0: uart_start for byte k+1 at cycle M+1.
  - With a gap: uart_start for byte k+1 at cycle M+1+gap_ms*CLK_FREQ/1000 (±1 cycle is not allowed).
- Final byte: done high in cycle M+1, and bytes_sent already equals tx_count in that cycle.
- bytes_sent updates in the cycle after each busy fall and wraps never, since it is at most 255.

## Structure
- Package tx_sched_pkg holds:
  - the state enum;
  - MS_DIV = CLK_FREQ/1000;
  - the bcd_to_bin function with clamping.
- Sub-module ms_tick_gen(CLK_FREQ):
  - Inputs clk, reset, clear; output tick, a one-cycle pulse every MS_DIV cycles.
  - Instantiated once, with clear driven on GAP entry.
- Counters:
  - remaining: 8 bits.
  - gap counter: 7 bits, maximum 99.
  - tick divider: $clog2(MS_DIV) bits.

## Test plan
- tx_byte=0xA5, tx_count=1, gap 0x00, start → one uart_start with uart_data=0xA5, done one cycle after busy falls, bytes_sent=1.
- tx_count=0x20, gap 0x00, UART model busy for 10 cycles → 32 starts, each exactly one cycle after the previous busy fall, bytes_sent=0x20.
- CLK_FREQ=10_000, tx_count=3, gap 0x05 → byte-to-byte spacing after busy fall = 5×10 cycles + 1; 3 starts, then done.
- tx_count=0xFF, abort asserted after the 4th busy fall → done pulses, bytes_sent=4, no further uart_start.
- start pulsed again mid-burst with different tx_byte → ignored, uart_data unchanged; tx_count=0 → done at N+1 with no uart_start.
- reset asserted during GAP → all outputs at reset values immediately, state IDLE, no done pulse; gap_bcd=0xFF decodes to 99 ms.
